// File: rtl/wb_seq_master.sv
// Wishbone classic-cycle initiator: one single-word transfer per word at sequential addresses.
// Define WB_TIMEOUT_EN to abort a command (done+err) when ack does not arrive within TIMEOUT_CYC cycles.
module wb_seq_master #(
  parameter int LEN_W = 16
`ifdef WB_TIMEOUT_EN
  ,
  parameter int TIMEOUT_CYC = 256
`endif
) (
  input  logic             wb_clk_i,
  input  logic             wb_rst_i,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic             cmd_we,
  input  logic [31:0]      cmd_addr,
  input  logic [LEN_W-1:0] cmd_len,
  input  logic [31:0]      wr_data,
  input  logic             wr_valid,
  output logic             wr_ready,
  output logic [31:0]      rd_data,
  output logic             rd_valid,
  input  logic             rd_ready,
  output logic             done,
  output logic             err,
  output logic             wbm_cyc_o,
  output logic             wbm_stb_o,
  output logic             wbm_we_o,
  output logic [3:0]       wbm_sel_o,
  output logic [31:0]      wbm_adr_o,
  output logic [31:0]      wbm_dat_o,
  input  logic [31:0]      wbm_dat_i,
  input  logic             wbm_ack_i
);

  typedef enum logic [2:0] {
    IDLE,
    WFETCH,
    BUS,
    RHOLD,
    FIN
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;

  logic [31:0]      r_addr;
  logic [LEN_W-1:0] r_rem;
  logic             r_we;
  logic [31:0]      r_dat_o;
  logic [31:0]      r_rd_data;
  logic             r_cyc;
  logic             r_we_o;
  logic [3:0]       r_sel;
  logic             r_wr_ready;
  logic             r_rd_valid;
  logic             r_done;
  logic             r_cmd_ready;

  logic [31:0]      w_addr_nxt;
  logic [LEN_W-1:0] w_rem_nxt;
  logic             w_we_nxt;
  logic [31:0]      w_dat_o_nxt;
  logic [31:0]      w_rd_data_nxt;
  logic             w_last;
  logic             w_timeout;
  logic             w_unused_addr;

  // Word addresses only; the byte offset of the command address is discarded.
  assign w_unused_addr = ^cmd_addr[1:0];
  assign w_last        = (r_rem == LEN_W'(1));

`ifdef WB_TIMEOUT_EN
  localparam int TMO_W = $clog2(TIMEOUT_CYC + 1);

  logic [TMO_W-1:0] r_tmo_cnt;
  logic             r_err;

  // BUS is never re-entered directly from BUS, so holding the counter at zero elsewhere clears it on entry.
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      r_tmo_cnt <= '0;
    end else if (r_state != BUS) begin
      r_tmo_cnt <= '0;
    end else if (!wbm_ack_i) begin
      r_tmo_cnt <= r_tmo_cnt + TMO_W'(1);
    end
  end

  assign w_timeout = (r_state == BUS) && !wbm_ack_i &&
                     (r_tmo_cnt == TMO_W'(TIMEOUT_CYC - 1));

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      r_err <= 1'b0;
    end else begin
      r_err <= (w_state_nxt == FIN) && w_timeout;
    end
  end

  assign err = r_err;
`else
  assign w_timeout = 1'b0;
  assign err       = 1'b0;
`endif

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE: begin
        if (cmd_valid) begin
          if (cmd_len == '0) begin
            w_state_nxt = FIN;
          end else if (cmd_we) begin
            w_state_nxt = WFETCH;
          end else begin
            w_state_nxt = BUS;
          end
        end
      end
      WFETCH: begin
        if (wr_valid) begin
          w_state_nxt = BUS;
        end
      end
      BUS: begin
        if (wbm_ack_i) begin
          if (!r_we) begin
            w_state_nxt = RHOLD;
          end else if (w_last) begin
            w_state_nxt = FIN;
          end else begin
            w_state_nxt = WFETCH;
          end
        end else if (w_timeout) begin
          w_state_nxt = FIN;
        end
      end
      RHOLD: begin
        if (rd_ready) begin
          w_state_nxt = w_last ? FIN : BUS;
        end
      end
      FIN:     w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  // The word pointer advances only once a word is fully retired (write acked, read data consumed).
  always_comb begin
    w_addr_nxt    = r_addr;
    w_rem_nxt     = r_rem;
    w_we_nxt      = r_we;
    w_dat_o_nxt   = r_dat_o;
    w_rd_data_nxt = r_rd_data;
    case (r_state)
      IDLE: begin
        if (cmd_valid) begin
          w_addr_nxt = {cmd_addr[31:2], 2'b00};
          w_rem_nxt  = cmd_len;
          w_we_nxt   = cmd_we;
        end
      end
      WFETCH: begin
        if (wr_valid) begin
          w_dat_o_nxt = wr_data;
        end
      end
      BUS: begin
        if (wbm_ack_i) begin
          if (r_we) begin
            w_addr_nxt = r_addr + 32'd4;
            w_rem_nxt  = r_rem - LEN_W'(1);
          end else begin
            w_rd_data_nxt = wbm_dat_i;
          end
        end
      end
      RHOLD: begin
        if (rd_ready) begin
          w_addr_nxt = r_addr + 32'd4;
          w_rem_nxt  = r_rem - LEN_W'(1);
        end
      end
      default: ;
    endcase
  end

  // Every output is a register whose next value is decoded from the next state.
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      r_addr      <= '0;
      r_rem       <= '0;
      r_we        <= 1'b0;
      r_dat_o     <= '0;
      r_rd_data   <= '0;
      r_cyc       <= 1'b0;
      r_we_o      <= 1'b0;
      r_sel       <= 4'h0;
      r_wr_ready  <= 1'b0;
      r_rd_valid  <= 1'b0;
      r_done      <= 1'b0;
      r_cmd_ready <= 1'b1;
    end else begin
      r_addr      <= w_addr_nxt;
      r_rem       <= w_rem_nxt;
      r_we        <= w_we_nxt;
      r_dat_o     <= w_dat_o_nxt;
      r_rd_data   <= w_rd_data_nxt;
      r_cyc       <= (w_state_nxt == BUS);
      r_we_o      <= (w_state_nxt == BUS) && w_we_nxt;
      r_sel       <= {4{w_state_nxt == BUS}};
      r_wr_ready  <= (w_state_nxt == WFETCH);
      r_rd_valid  <= (w_state_nxt == RHOLD);
      r_done      <= (w_state_nxt == FIN);
      r_cmd_ready <= (w_state_nxt == IDLE);
    end
  end

  assign cmd_ready = r_cmd_ready;
  assign wr_ready  = r_wr_ready;
  assign rd_data   = r_rd_data;
  assign rd_valid  = r_rd_valid;
  assign done      = r_done;
  assign wbm_cyc_o = r_cyc;
  assign wbm_stb_o = r_cyc;
  assign wbm_we_o  = r_we_o;
  assign wbm_sel_o = r_sel;
  assign wbm_adr_o = r_addr;
  assign wbm_dat_o = r_dat_o;

endmodule

// File: tb/tb_wb_seq_master.sv
// Scoreboard bench for wb_seq_master: a small Wishbone slave memory plus queues of expected
// bus transfers, read words and done pulses that a negedge monitor pops and compares.
`ifdef WB_TIMEOUT_EN
`define TB_DUT_PARAMS .LEN_W(16), .TIMEOUT_CYC(8)
`else
`define TB_DUT_PARAMS .LEN_W(16)
`endif

module tb_wb_seq_master;

  logic        clk = 1'b0;
  logic        rst;
  logic        cmd_valid;
  logic        cmd_ready;
  logic        cmd_we;
  logic [31:0] cmd_addr;
  logic [15:0] cmd_len;
  logic [31:0] wr_data;
  logic        wr_valid;
  logic        wr_ready;
  logic [31:0] rd_data;
  logic        rd_valid;
  logic        rd_ready;
  logic        done;
  logic        err;
  logic        cyc;
  logic        stb;
  logic        we;
  logic [3:0]  sel;
  logic [31:0] adr;
  logic [31:0] dat_o;
  logic [31:0] dat_i;
  logic        ack;

  int          errors = 0;
  int          checks = 0;
  int          ackMode = 1;
  logic        rAck = 1'b0;
  logic        memInit = 1'b1;
  logic [31:0] mem [0:63];

  logic [64:0] expBus [$];
  logic [31:0] expRd [$];
  logic        expDone [$];

  wb_seq_master #(`TB_DUT_PARAMS) dut (
    .wb_clk_i  (clk),
    .wb_rst_i  (rst),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_we    (cmd_we),
    .cmd_addr  (cmd_addr),
    .cmd_len   (cmd_len),
    .wr_data   (wr_data),
    .wr_valid  (wr_valid),
    .wr_ready  (wr_ready),
    .rd_data   (rd_data),
    .rd_valid  (rd_valid),
    .rd_ready  (rd_ready),
    .done      (done),
    .err       (err),
    .wbm_cyc_o (cyc),
    .wbm_stb_o (stb),
    .wbm_we_o  (we),
    .wbm_sel_o (sel),
    .wbm_adr_o (adr),
    .wbm_dat_o (dat_o),
    .wbm_dat_i (dat_i),
    .wbm_ack_i (ack)
  );

  always #5 clk = ~clk;

  // Slave: mode 0 acks in the strobe cycle, mode 1 one cycle later, mode 2 never.
  assign dat_i = mem[adr[7:2]];
  assign ack   = (ackMode == 0) ? (cyc & stb) : (ackMode == 1) ? rAck : 1'b0;

  always @(posedge clk) begin
    rAck <= (ackMode == 1) && cyc && stb && !rAck;
    if (memInit) begin
      for (int i = 0; i < 64; i++) mem[i] <= 32'hD000_0000 + 32'(i);
    end else if (cyc && stb && ack && we) begin
      mem[adr[7:2]] <= dat_o;
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic failNow(input string name);
    checks++;
    errors++;
    $display("[TB] FAIL %s: got no event expected event", name);
  endtask

  // Monitor: pops one expectation per observed transfer, read handshake or done pulse.
  always @(negedge clk) begin
    logic [64:0] e;
    if (!rst) begin
      if (cyc) begin
        checkOutput("stb_with_cyc", 32'(stb), 32'd1);
        checkOutput("sel_with_cyc", 32'(sel), 32'hF);
      end else begin
        checkOutput("stb_idle", 32'(stb), 32'd0);
        checkOutput("sel_idle", 32'(sel), 32'd0);
      end
      if (cyc && stb && ack) begin
        if (expBus.size() == 0) begin
          failNow("unexpected_bus_transfer");
        end else begin
          e = expBus.pop_front();
          checkOutput("bus_adr", adr, e[63:32]);
          checkOutput("bus_we", 32'(we), 32'(e[64]));
          if (e[64]) checkOutput("bus_dat", dat_o, e[31:0]);
        end
      end
      if (rd_valid && rd_ready) begin
        if (expRd.size() == 0) failNow("unexpected_read_word");
        else checkOutput("rd_data", rd_data, expRd.pop_front());
      end
      if (done) begin
        if (expDone.size() == 0) failNow("unexpected_done");
        else checkOutput("err_with_done", 32'(err), 32'(expDone.pop_front()));
      end
    end
  end

  task automatic waitHigh(input int which, input string name);
    int   k;
    logic s;
    k = 0;
    do begin
      @(negedge clk);
      k++;
      s = (which == 0) ? cmd_ready : (which == 1) ? wr_ready : rd_valid;
    end while (!s && k < 100);
    if (!s) failNow(name);
  endtask

  task automatic waitDone(output int cycles);
    cycles = 0;
    do begin
      @(negedge clk);
      cycles++;
    end while (!done && cycles < 200);
    if (!done) failNow("done_wait");
    @(negedge clk);
    checkOutput("done_one_cycle", 32'(done), 32'd0);
    checkOutput("cmd_ready_after_done", 32'(cmd_ready), 32'd1);
  endtask

  task automatic applyStimulus(input logic we_i, input logic [31:0] addr, input logic [15:0] len,
                               input logic [31:0] base, input int stallWord, input int stallCycles);
    logic [31:0] a0;
    int          lat;
    a0 = {addr[31:2], 2'b00};
    @(posedge clk);
    #1;
    for (int i = 0; i < int'(len); i++) begin
      expBus.push_back({we_i, a0 + 32'(4 * i), we_i ? base + 32'(i) : 32'h0});
      if (!we_i) expRd.push_back(base + 32'(i));
    end
    expDone.push_back(1'b0);
    cmd_valid = 1'b1;
    cmd_we    = we_i;
    cmd_addr  = addr;
    cmd_len   = len;
    waitHigh(0, "cmd_ready_wait");
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
    for (int i = 0; i < int'(len); i++) begin
      if (we_i) begin
        wr_data  = base + 32'(i);
        wr_valid = 1'b1;
        waitHigh(1, "wr_ready_wait");
        @(posedge clk);
        #1;
        wr_valid = 1'b0;
      end else begin
        rd_ready = (i != stallWord);
        waitHigh(2, "rd_valid_wait");
        if (i == stallWord) begin
          repeat (stallCycles) begin
            checkOutput("stall_no_cyc", 32'(cyc), 32'd0);
            checkOutput("stall_rd_valid", 32'(rd_valid), 32'd1);
            checkOutput("stall_rd_data", rd_data, base + 32'(i));
            @(negedge clk);
          end
          @(posedge clk);
          #1;
          rd_ready = 1'b1;
          waitHigh(2, "rd_valid_resume");
        end
        @(posedge clk);
        #1;
      end
    end
    rd_ready = 1'b1;
    waitDone(lat);
    if (len == 16'd0) checkOutput("zero_len_done_latency", 32'(lat), 32'd1);
  endtask

  initial begin
    rst       = 1'b1;
    cmd_valid = 1'b0;
    cmd_we    = 1'b0;
    cmd_addr  = '0;
    cmd_len   = '0;
    wr_data   = '0;
    wr_valid  = 1'b0;
    rd_ready  = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    memInit = 1'b0;
    @(negedge clk);
    checkOutput("rst_cyc", 32'(cyc), 32'd0);
    checkOutput("rst_stb", 32'(stb), 32'd0);
    checkOutput("rst_we", 32'(we), 32'd0);
    checkOutput("rst_sel", 32'(sel), 32'd0);
    checkOutput("rst_adr", adr, 32'd0);
    checkOutput("rst_dat_o", dat_o, 32'd0);
    checkOutput("rst_rd_valid", 32'(rd_valid), 32'd0);
    checkOutput("rst_rd_data", rd_data, 32'd0);
    checkOutput("rst_wr_ready", 32'(wr_ready), 32'd0);
    checkOutput("rst_done", 32'(done), 32'd0);
    checkOutput("rst_err", 32'(err), 32'd0);
    checkOutput("rst_cmd_ready", 32'(cmd_ready), 32'd1);
    @(posedge clk);
    #1;
    rst = 1'b0;

    ackMode = 1;
    applyStimulus(1'b1, 32'h0000_0010, 16'd3, 32'hA5A5_0001, -1, 0);
    applyStimulus(1'b0, 32'h0000_0010, 16'd3, 32'hA5A5_0001, 1, 5);

    ackMode = 0;
    applyStimulus(1'b1, 32'h0000_0040, 16'd2, 32'h1234_0000, -1, 0);
    applyStimulus(1'b0, 32'h0000_0042, 16'd2, 32'h1234_0000, -1, 0);
    applyStimulus(1'b1, 32'h0000_0080, 16'd0, 32'h0, -1, 0);
    applyStimulus(1'b1, 32'hFFFF_FFFC, 16'd2, 32'hC0DE_0000, -1, 0);
    applyStimulus(1'b0, 32'hFFFF_FFFF, 16'd2, 32'hC0DE_0000, -1, 0);

    // Reset while word 2 of a 4-word read is on the bus.
    ackMode = 1;
    @(posedge clk);
    #1;
    expBus.push_back({1'b0, 32'h0000_0020, 32'h0});
    expRd.push_back(32'hD000_0008);
    cmd_valid = 1'b1;
    cmd_we    = 1'b0;
    cmd_addr  = 32'h0000_0020;
    cmd_len   = 16'd4;
    waitHigh(0, "rst_cmd_ready_wait");
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
    rd_ready  = 1'b1;
    waitHigh(2, "rst_rd_valid_wait");
    @(posedge clk);
    #1;
    rst = 1'b1;
    @(negedge clk);
    checkOutput("mid_bus_cyc", 32'(cyc), 32'd1);
    @(negedge clk);
    checkOutput("midrst_cyc", 32'(cyc), 32'd0);
    checkOutput("midrst_stb", 32'(stb), 32'd0);
    checkOutput("midrst_rd_valid", 32'(rd_valid), 32'd0);
    checkOutput("midrst_cmd_ready", 32'(cmd_ready), 32'd1);
    checkOutput("midrst_done", 32'(done), 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    repeat (6) @(negedge clk);

`ifdef WB_TIMEOUT_EN
    begin
      int cycHigh;
      int k;
      ackMode = 2;
      @(posedge clk);
      #1;
      expDone.push_back(1'b1);
      cmd_valid = 1'b1;
      cmd_we    = 1'b0;
      cmd_addr  = 32'h0000_0010;
      cmd_len   = 16'd2;
      waitHigh(0, "tmo_cmd_ready_wait");
      @(posedge clk);
      #1;
      cmd_valid = 1'b0;
      cycHigh = 0;
      k = 0;
      do begin
        @(negedge clk);
        k++;
        if (cyc) cycHigh++;
      end while (!done && k < 100);
      if (!done) failNow("tmo_done_wait");
      checkOutput("tmo_cyc_cycles", 32'(cycHigh), 32'd8);
      checkOutput("tmo_err", 32'(err), 32'd1);
      @(negedge clk);
      checkOutput("tmo_err_one_cycle", 32'(err), 32'd0);
      ackMode = 0;
      applyStimulus(1'b0, 32'h0000_0010, 16'd1, 32'hA5A5_0001, -1, 0);
    end
`endif

    repeat (3) @(negedge clk);
    checkOutput("exp_bus_drained", 32'(expBus.size()), 32'd0);
    checkOutput("exp_rd_drained", 32'(expRd.size()), 32'd0);
    checkOutput("exp_done_drained", 32'(expDone.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/wb_seq_master.md
Name: wb_seq_master

Overview:
- Wishbone classic-cycle initiator that drives the user-area Wishbone slave port of the SDRAM-backed system RAM.
- Accepts a command (start address, word count, direction) and issues one single-word transfer per word, at sequential addresses.
- Write data enters from a valid/ready stream. Read data leaves through a valid/ready stream.
- Used as a test/DMA engine next to the SDRAM controller path, driven from LA or firmware-side glue.

Parameters:
LEN_W, 16, width of the word-count field
TIMEOUT_CYC, 256, cycles of cyc/stb without ack before abort (only when WB_TIMEOUT_EN is defined)

Ports:
wb_clk_i  input  1  clock
wb_rst_i  input  1  synchronous active-high reset
cmd_valid  input  1  command offered
cmd_ready  output  1  high only in IDLE
cmd_we  input  1  1 = write burst, 0 = read burst
cmd_addr  input  32  start byte address; bits [1:0] ignored, treated as 0
cmd_len  input  LEN_W  number of words; 0 = no-op
wr_data  input  32  write stream data
wr_valid  input  1  write stream valid
wr_ready  output  1  write stream ready
rd_data  output  32  read stream data
rd_valid  output  1  read stream valid
rd_ready  input  1  read stream ready
done  output  1  one-cycle pulse when a command finishes
err  output  1  one-cycle pulse, coincident with done, on timeout abort
wbm_cyc_o  output  1  Wishbone cycle
wbm_stb_o  output  1  Wishbone strobe, always equal to cyc
wbm_we_o  output  1  Wishbone write enable
wbm_sel_o  output  4  byte selects, always 4'hF during a cycle, 0 otherwise
wbm_adr_o  output  32  Wishbone address
wbm_dat_o  output  32  Wishbone write data
wbm_dat_i  input  32  Wishbone read data
wbm_ack_i  input  1  Wishbone acknowledge

Behaviour:
- Single clock wb_clk_i. Reset wb_rst_i is synchronous, active-high.
- All outputs are registered.
- Reset values:
  - cyc, stb, we, sel, adr, dat_o: 0
  - rd_valid, rd_data: 0
  - wr_ready, done, err: 0
  - cmd_ready: 1
  - FSM: IDLE
- Reset mid-operation: all bus signals drop the cycle after reset is sampled. The command is discarded. No done pulse.
- FSM states: IDLE, WFETCH, BUS, RHOLD, FIN.
- IDLE:
  - cmd_ready=1.
  - On cmd_valid: latch addr (with [1:0] cleared), len, and we.
  - len==0: go to FIN.
  - len>0 and we=1: go to WFETCH.
  - len>0 and we=0: go to BUS, with cyc/stb asserted in the next cycle.
- WFETCH:
  - wr_ready=1.
  - On wr_valid: capture wr_data into dat_o, drop wr_ready, go to BUS.
- BUS:
  - cyc=stb=1, adr=current address, we=latched direction.
  - Cycle N with ack=1: cyc/stb low in cycle N+1. For a read, wbm_dat_i is captured into rd_data in cycle N.
  - Read: go to RHOLD with rd_valid=1 from cycle N+1.
  - Write: address += 4 and remaining -= 1. Then go to FIN if remaining becomes 0, else to WFETCH.
- RHOLD:
  - rd_valid held with rd_data stable until rd_ready.
  - On the handshake: address += 4 and remaining -= 1. Then go to FIN if remaining becomes 0, else to BUS.
  - No bus cycle is issued while read data is unconsumed. Only one word is ever in flight.
- FIN: done=1 for one cycle, then go to IDLE.
- Address arithmetic: 32-bit, wraps 32'hFFFF_FFFC -> 32'h0000_0000 silently.
- Max burst: 2^LEN_W-1 words.
- ack while not in BUS: ignored.
- cmd_valid outside IDLE: ignored, not queued.
- Throughput minimums:
  - Read word: 1 cycle BUS with zero-wait ack, plus 1 cycle RHOLD.
  - Write word: 1 cycle WFETCH plus 1 cycle BUS.

Optional Feature:
- Macro WB_TIMEOUT_EN.
- Defined:
  - A counter clears on entry to BUS and increments each BUS cycle without ack.
  - When it reaches TIMEOUT_CYC: cyc/stb drop next cycle, go to FIN, and err pulses with done.
  - The remaining words are abandoned.
- Undefined:
  - No counter. BUS waits indefinitely.
  - err is tied to 0.

Test Plan:
- Write burst: cmd_we=1, addr=0x0000_0010, len=3; stream 0xA5A5_0001..0003; slave acks 1 cycle after stb -> three cycles at adr 0x10/0x14/0x18 with dat_o matching and sel=F; done pulses once; err=0.
- Read-back: cmd_we=0, addr=0x10, len=3 -> rd_data 0xA5A5_0001..0003 in order. Hold rd_ready=0 for 5 cycles on word 2 -> no bus cycle during the stall, rd_data stable.
- Handshake/ack timing: slave acks in the same cycle stb rises -> stb low the next cycle; no duplicate transfer; address advances exactly once.
- Zero/wrap: len=0 -> done one cycle after acceptance with no cyc. addr=0xFFFF_FFFC, len=2 -> adr 0xFFFF_FFFC then 0x0000_0000.
- Reset mid-burst: assert wb_rst_i during BUS of word 2 of 4 -> cyc/stb/rd_valid low the next cycle; cmd_ready=1; no done.
- WB_TIMEOUT_EN with TIMEOUT_CYC=8, slave never acks -> cyc drops after 8 BUS cycles; done=err=1 for one cycle; next command accepted normally.
